// File: rtl/dma_arbiter.sv
`timescale 1ns/1ps
// dma_arbiter: takes the bus from the CPU on behalf of NREQ DMA requesters.
// The bus is held while requests exist, ownership rotates round-robin, bursts
// are capped at MAXBURST acknowledged transfers when others are waiting, and a
// stalled transfer is aborted with a one-cycle bus_err after TMO cycles.
module dma_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int TMO      = 63
) (
    input  logic            clk_p,
    input  logic            dclo_n,
    input  logic [NREQ-1:0] dma_req,
    input  logic [NREQ-1:0] dma_stb,
    input  logic            cpu_stb,
    input  logic            global_ack,
    output logic            bus_gnt,
    output logic [NREQ-1:0] dma_gnt,
    output logic [2:0]      gnt_idx,
    output logic            bus_stb,
    output logic            bus_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GRANT, ST_REL} state_t;

    state_t          state;
    logic [2:0]      rr_ptr;      // last owner; scan starts one above it
    logic [7:0]      burst_cnt;
    logic [7:0]      tmo_cnt;

    logic [7:0]      req_ext;
    logic [7:0]      stb_ext;
    logic [2:0]      win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            owner_req;
    logic            others_req;
    logic            xfer;
    logic            stall;
    logic            burst_hit;
    logic            tmo_hit;
    logic            grant_done;

    // Zero-extend the request/strobe vectors to 8 bits so a 3-bit index can select any bit.
    // NOTE: every signal driven from always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        req_ext            = '0;
        stb_ext            = '0;
        req_ext[NREQ-1:0]  = dma_req;
        stb_ext[NREQ-1:0]  = dma_stb;
    end

    // Round-robin search: first requesting index scanning upward from rr_ptr+1, wrapping.
    always_comb begin
        logic [3:0] cand;
        logic       found;
        cand    = '0;
        found   = 1'b0;
        win_idx = rr_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!found && req_ext[cand[2:0]]) begin
                win_idx = cand[2:0];
                found   = 1'b1;
            end
        end
    end

    // One-hot form of the winner, loaded into dma_gnt on GRANT entry.
    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_onehot[i] = (win_idx == 3'(i));
        end
    end

    // The owner's strobe reaches the bus only while the grant is live.
    assign bus_stb    = (state == ST_GRANT) && stb_ext[gnt_idx];
    assign owner_req  = req_ext[gnt_idx];
    assign others_req = |(req_ext & ~(8'd1 << gnt_idx));
    assign xfer       = bus_stb && global_ack;
    assign stall      = bus_stb && !global_ack;
    assign burst_hit  = xfer && (burst_cnt + 8'd1 == 8'(MAXBURST));
    assign tmo_hit    = stall && (tmo_cnt + 8'd1 == 8'(TMO));
    assign grant_done = (!bus_stb && !owner_req) || (burst_hit && others_req) || tmo_hit;

    // Arbiter FSM with registered grant outputs, burst and timeout counters.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_p or negedge dclo_n) begin
        if (!dclo_n) begin
            state     <= ST_IDLE;
            bus_gnt   <= 1'b0;
            dma_gnt   <= '0;
            gnt_idx   <= 3'd0;
            bus_err   <= 1'b0;
            burst_cnt <= 8'd0;
            tmo_cnt   <= 8'd0;
            rr_ptr    <= 3'(NREQ - 1);
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    burst_cnt <= 8'd0;
                    tmo_cnt   <= 8'd0;
                    if (|dma_req) begin
                        state   <= ST_HOLD;
                        bus_gnt <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    burst_cnt <= 8'd0;
                    tmo_cnt   <= 8'd0;
                    if (!(|dma_req)) begin
                        state   <= ST_IDLE;
                        bus_gnt <= 1'b0;
                    end else if (!cpu_stb) begin
                        state   <= ST_GRANT;
                        dma_gnt <= win_onehot;
                        gnt_idx <= win_idx;
                        rr_ptr  <= win_idx;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_hit ? 8'd0 : burst_cnt + 8'd1;
                    end
                    if (stall) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end else begin
                        tmo_cnt <= 8'd0;
                    end
                    if (tmo_hit) begin
                        bus_err <= 1'b1;
                    end
                    if (grant_done) begin
                        state   <= ST_REL;
                        dma_gnt <= '0;
                    end
                end
                ST_REL: begin
                    burst_cnt <= 8'd0;
                    tmo_cnt   <= 8'd0;
                    if (|dma_req) begin
                        state <= ST_HOLD;
                    end else begin
                        state   <= ST_IDLE;
                        bus_gnt <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus_gnt <= 1'b0;
                    dma_gnt <= '0;
                end
            endcase
        end
    end

endmodule
